// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared constants and types for the pipeline hazard/forwarding controller.
//   - FWD_* : Execute operand-mux select encodings.
//   - mdu_state_t : occupancy states of the multi-cycle MDU tracker.
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FWD_REG     = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_RESULTW = 2'b01;  // operand from Writeback result
   localparam logic [1:0] FWD_ALUOUTM = 2'b10;  // operand from Memory-stage ALU output

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle of the pipeline-status inputs and the forward/stall/flush outputs
//   of the hazard controller.
//   master : pipeline datapath side (drives stage status, receives controls)
//   slave  : hazard controller side (receives stage status, drives controls)
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);

   // Stage status from the datapath
   logic [REG_ADDR_W-1:0] rs_d;
   logic [REG_ADDR_W-1:0] rt_d;
   logic [REG_ADDR_W-1:0] rs_e;
   logic [REG_ADDR_W-1:0] rt_e;
   logic [REG_ADDR_W-1:0] write_reg_e;
   logic [REG_ADDR_W-1:0] write_reg_m;
   logic [REG_ADDR_W-1:0] write_reg_w;
   logic                  reg_write_e;
   logic                  reg_write_m;
   logic                  reg_write_w;
   logic                  mem_to_reg_e;
   logic                  mem_to_reg_m;
   logic                  branch_d;
   logic                  pc_src_d;
   logic                  jump_d;
   logic                  mdu_op_e;

   // Controls back to the datapath
   logic [1:0]            forward_a_e;
   logic [1:0]            forward_b_e;
   logic                  forward_a_d;
   logic                  forward_b_d;
   logic                  stall_f;
   logic                  stall_d;
   logic                  stall_e;
   logic                  flush_d;
   logic                  flush_e;
   logic                  flush_m;
   logic                  mdu_busy;

   modport master (
      output rs_d, rt_d, rs_e, rt_e,
      output write_reg_e, write_reg_m, write_reg_w,
      output reg_write_e, reg_write_m, reg_write_w,
      output mem_to_reg_e, mem_to_reg_m,
      output branch_d, pc_src_d, jump_d, mdu_op_e,
      input  forward_a_e, forward_b_e, forward_a_d, forward_b_d,
      input  stall_f, stall_d, stall_e,
      input  flush_d, flush_e, flush_m, mdu_busy
   );

   modport slave (
      input  rs_d, rt_d, rs_e, rt_e,
      input  write_reg_e, write_reg_m, write_reg_w,
      input  reg_write_e, reg_write_m, reg_write_w,
      input  mem_to_reg_e, mem_to_reg_m,
      input  branch_d, pc_src_d, jump_d, mdu_op_e,
      output forward_a_e, forward_b_e, forward_a_d, forward_b_d,
      output stall_f, stall_d, stall_e,
      output flush_d, flush_e, flush_m, mdu_busy
   );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_occupancy_fsm.sv
// ---------------------------------------------------------------------------
// mdu_occupancy_fsm
//   Tracks how long a multi-cycle MDU op has been sitting in Execute and
//   holds the pipeline until it has occupied Execute for MDU_LATENCY cycles.
//
//   clk       in  rising-edge clock
//   reset     in  asynchronous, active-low reset (aborts any op in flight)
//   mdu_op_e  in  Execute holds an MDU op
//   mdu_stall out hold Execute / bubble Memory this cycle (combinational)
//   mdu_busy  out FSM is in BUSY
// ---------------------------------------------------------------------------
module mdu_occupancy_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic mdu_op_e,
   output logic mdu_stall,
   output logic mdu_busy
);

   // Counter only has to hold MDU_LATENCY-2; keep at least one bit.
   localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);

   mdu_state_t       state, nextState;
   logic [CNT_W-1:0] cnt, nextCnt;

   // The entry cycle stalls from IDLE, then BUSY counts down the remaining
   // held cycles; the cnt==0 BUSY cycle is the op's last one in Execute.
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      mdu_stall = 1'b0;
      unique case (state)
         MDU_IDLE: begin
            if (mdu_op_e && (MDU_LATENCY > 1)) begin
               mdu_stall = 1'b1;
               nextCnt   = CNT_INIT;
               nextState = MDU_BUSY;
            end
         end
         MDU_BUSY: begin
            if (cnt != '0) begin
               mdu_stall = 1'b1;
               nextCnt   = cnt - 1'b1;
            end else begin
               nextState = MDU_IDLE;
            end
         end
         default: nextState = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= MDU_IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   assign mdu_busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the 5-stage pipeline: Execute and
//   Decode forwarding selects, load-use / branch-in-Decode stalls, and the
//   multi-cycle MDU hold of Execute.
//
//   clk    in     rising-edge clock
//   reset  in     asynchronous, active-low reset
//   hz     slave  stage status in; forward/stall/flush/mdu_busy out
//
//   Optional build macro HAZARD_PERF_CNT_EN adds saturating counters:
//   stall_cycles  out PERF_CNT_W  cycles with stall_f high
//   fwd_events    out PERF_CNT_W  cycles with any forward select active
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MDU_LATENCY = 4,
   parameter int PERF_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipe_hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cycles,
   output logic [PERF_CNT_W-1:0] fwd_events
`endif
);

   logic lwStall;
   logic brStall;
   logic mduStall;
   logic anyStall;

   // Memory stage has the newer value, so it takes priority over Writeback.
   function automatic logic [1:0] exFwdSel(
      input logic [REG_ADDR_W-1:0] src,
      input logic                  rwM,
      input logic [REG_ADDR_W-1:0] wrM,
      input logic                  rwW,
      input logic [REG_ADDR_W-1:0] wrW
   );
      if (src != '0 && rwM && wrM == src) return FWD_ALUOUTM;
      if (src != '0 && rwW && wrW == src) return FWD_RESULTW;
      return FWD_REG;
   endfunction

   // Destination matches either Decode source; register 0 never matches.
   function automatic logic hitsDecode(
      input logic [REG_ADDR_W-1:0] dst,
      input logic [REG_ADDR_W-1:0] srcS,
      input logic [REG_ADDR_W-1:0] srcT
   );
      return (dst != '0) && ((dst == srcS) || (dst == srcT));
   endfunction

   always_comb begin
      hz.forward_a_e = exFwdSel(hz.rs_e, hz.reg_write_m, hz.write_reg_m,
                                hz.reg_write_w, hz.write_reg_w);
      hz.forward_b_e = exFwdSel(hz.rt_e, hz.reg_write_m, hz.write_reg_m,
                                hz.reg_write_w, hz.write_reg_w);
   end

   assign hz.forward_a_d = hz.reg_write_m && (hz.write_reg_m == hz.rs_d) && (hz.rs_d != '0);
   assign hz.forward_b_d = hz.reg_write_m && (hz.write_reg_m == hz.rt_d) && (hz.rt_d != '0);

   assign lwStall = hz.mem_to_reg_e && (hz.rt_e != '0) &&
                    ((hz.rt_e == hz.rs_d) || (hz.rt_e == hz.rt_d));

   // The comparator in Decode needs the operand a cycle before Execute would,
   // so an ALU result still in E, or a load still in M, is too late.
   assign brStall = hz.branch_d &&
                    ((hz.reg_write_e  && hitsDecode(hz.write_reg_e, hz.rs_d, hz.rt_d)) ||
                     (hz.mem_to_reg_m && hitsDecode(hz.write_reg_m, hz.rs_d, hz.rt_d)));

   mdu_occupancy_fsm #(
      .MDU_LATENCY (MDU_LATENCY)
   ) uMduFsm (
      .clk       (clk),
      .reset     (reset),
      .mdu_op_e  (hz.mdu_op_e),
      .mdu_stall (mduStall),
      .mdu_busy  (hz.mdu_busy)
   );

   assign anyStall   = lwStall || brStall || mduStall;
   assign hz.stall_f = anyStall;
   assign hz.stall_d = anyStall;
   assign hz.stall_e = mduStall;
   assign hz.flush_m = mduStall;
   // A held MDU op keeps Execute occupied, so it must not be replaced by a bubble.
   assign hz.flush_e = (lwStall || brStall) && !mduStall;
   assign hz.flush_d = (hz.pc_src_d || hz.jump_d) && !anyStall;

`ifdef HAZARD_PERF_CNT_EN
   logic fwdAny;

   assign fwdAny = (hz.forward_a_e != FWD_REG) || (hz.forward_b_e != FWD_REG) ||
                   hz.forward_a_d || hz.forward_b_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         fwd_events   <= '0;
      end else begin
         if (anyStall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (fwdAny && (fwd_events != '1))     fwd_events   <= fwd_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int RAW = 5;
   localparam int LAT = 4;
   localparam int PCW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(RAW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [PCW-1:0] stallCycles;
   logic [PCW-1:0] fwdEvents;
`endif

   pipe_hazard_ctrl #(
      .REG_ADDR_W  (RAW),
      .MDU_LATENCY (LAT),
      .PERF_CNT_W  (PCW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .hz           (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles (stallCycles),
      .fwd_events   (fwdEvents)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   bit chkEn       = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // occ = which cycle (1-based) of its Execute residency the current MDU op
   // reached on the previous edge; 0 means no op has been resident.
   int occ = 0;
   int mStall = 0;
   int mFwd = 0;

   function automatic int age();
      if (occ > 0) return occ;
      return hz.mdu_op_e ? 1 : 0;
   endfunction

   function automatic int expMduStall();
      return (age() >= 1 && age() < LAT) ? 1 : 0;
   endfunction

   function automatic int expFwdE(input int src);
      if (src != 0 && hz.reg_write_m && int'(hz.write_reg_m) == src) return 2;
      if (src != 0 && hz.reg_write_w && int'(hz.write_reg_w) == src) return 1;
      return 0;
   endfunction

   function automatic int expFwdD(input int src);
      return (src != 0 && hz.reg_write_m && int'(hz.write_reg_m) == src) ? 1 : 0;
   endfunction

   function automatic int dHit(input int dst);
      return (dst != 0 && (dst == int'(hz.rs_d) || dst == int'(hz.rt_d))) ? 1 : 0;
   endfunction

   function automatic int expLw();
      return (hz.mem_to_reg_e && hz.rt_e != 0 &&
              (hz.rt_e == hz.rs_d || hz.rt_e == hz.rt_d)) ? 1 : 0;
   endfunction

   function automatic int expBr();
      if (!hz.branch_d) return 0;
      if (hz.reg_write_e && dHit(int'(hz.write_reg_e)) != 0) return 1;
      if (hz.mem_to_reg_m && dHit(int'(hz.write_reg_m)) != 0) return 1;
      return 0;
   endfunction

   function automatic int expStall();
      return (expLw() + expBr() + expMduStall()) > 0 ? 1 : 0;
   endfunction

   function automatic int expAnyFwd();
      return (expFwdE(int'(hz.rs_e)) + expFwdE(int'(hz.rt_e)) +
              expFwdD(int'(hz.rs_d)) + expFwdD(int'(hz.rt_d))) > 0 ? 1 : 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ    = 0;
         mStall = 0;
         mFwd   = 0;
      end else begin
         if (expStall() != 0 && mStall < (1 << PCW) - 1) mStall++;
         if (expAnyFwd() != 0 && mFwd < (1 << PCW) - 1) mFwd++;
         occ = (age() >= 1 && age() < LAT) ? age() + 1 : 0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chkEn) begin
         chk("fwdAE", int'(hz.forward_a_e), expFwdE(int'(hz.rs_e)));
         chk("fwdBE", int'(hz.forward_b_e), expFwdE(int'(hz.rt_e)));
         chk("fwdAD", int'(hz.forward_a_d), expFwdD(int'(hz.rs_d)));
         chk("fwdBD", int'(hz.forward_b_d), expFwdD(int'(hz.rt_d)));
         chk("stallF", int'(hz.stall_f), expStall());
         chk("stallD", int'(hz.stall_d), expStall());
         chk("stallE", int'(hz.stall_e), expMduStall());
         chk("flushM", int'(hz.flush_m), expMduStall());
         chk("flushE", int'(hz.flush_e),
             ((expLw() + expBr()) > 0 && expMduStall() == 0) ? 1 : 0);
         chk("flushD", int'(hz.flush_d),
             ((hz.pc_src_d || hz.jump_d) && expStall() == 0) ? 1 : 0);
         chk("mduBusy", int'(hz.mdu_busy), (occ >= 2) ? 1 : 0);
`ifdef HAZARD_PERF_CNT_EN
         chk("stallCycles", int'(stallCycles), mStall);
         chk("fwdEvents", int'(fwdEvents), mFwd);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      hz.rs_d = '0; hz.rt_d = '0; hz.rs_e = '0; hz.rt_e = '0;
      hz.write_reg_e = '0; hz.write_reg_m = '0; hz.write_reg_w = '0;
      hz.reg_write_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
      hz.mem_to_reg_e = 1'b0; hz.mem_to_reg_m = 1'b0;
      hz.branch_d = 1'b0; hz.pc_src_d = 1'b0; hz.jump_d = 1'b0;
      hz.mdu_op_e = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic setLoadUse5();
      hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1;
      hz.write_reg_e = 5'd5; hz.rt_e = 5'd5; hz.rt_d = 5'd5;
   endtask

   initial begin
      idle();
      #2;
      // reset state
      chk("rstBusy", int'(hz.mdu_busy), 0);
      chk("rstStallF", int'(hz.stall_f), 0);
      #10 reset = 1'b1;
      nextCycle();

      // Execute forwarding priority and register-0 exclusion
      hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3; hz.rs_e = 5'd3;
      settle(); chk("fwdM", int'(hz.forward_a_e), 2);
      hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd3;
      settle(); chk("fwdMoverW", int'(hz.forward_a_e), 2);
      hz.write_reg_m = 5'd4;
      settle(); chk("fwdW", int'(hz.forward_a_e), 1);
      hz.rt_e = 5'd4;
      settle(); chk("fwdBM", int'(hz.forward_b_e), 2);
      hz.rs_e = '0; hz.write_reg_m = '0;
      settle(); chk("fwdZero", int'(hz.forward_a_e), 0);

      // load-use: stall one cycle, then forward from W
      idle(); setLoadUse5();
      settle();
      chk("lwStallF", int'(hz.stall_f), 1);
      chk("lwStallD", int'(hz.stall_d), 1);
      chk("lwFlushE", int'(hz.flush_e), 1);
      chk("lwStallE", int'(hz.stall_e), 0);
      nextCycle();
      idle();
      hz.mem_to_reg_m = 1'b1; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd5; hz.rt_d = 5'd5;
      settle(); chk("lwReleased", int'(hz.stall_f), 0);
      nextCycle();
      idle();
      hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd5; hz.rs_e = 5'd5;
      settle(); chk("lwFwdW", int'(hz.forward_a_e), 1);

      // branch in Decode on $2
      idle();
      hz.branch_d = 1'b1; hz.rs_d = 5'd2; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd2;
      settle(); chk("brStall", int'(hz.stall_d), 1);
      chk("brFlushE", int'(hz.flush_e), 1);
      nextCycle();
      hz.reg_write_e = 1'b0; hz.write_reg_e = '0;
      hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd2;
      settle(); chk("brFwdD", int'(hz.forward_a_d), 1);
      chk("brNoStall", int'(hz.stall_d), 0);
      idle();
      hz.branch_d = 1'b1; hz.reg_write_e = 1'b1;
      settle(); chk("brReg0", int'(hz.stall_d), 0);

      // MDU op held for LAT cycles, with a concurrent load-use hazard
      idle();
      hz.mdu_op_e = 1'b1;
      setLoadUse5();
      for (int c = 1; c <= LAT; c++) begin
         if (c == LAT) begin
            hz.mem_to_reg_e = 1'b0;
            hz.rt_e = '0;
         end
         settle();
         chk($sformatf("mduStallE%0d", c), int'(hz.stall_e), (c < LAT) ? 1 : 0);
         chk($sformatf("mduFlushM%0d", c), int'(hz.flush_m), (c < LAT) ? 1 : 0);
         chk($sformatf("mduBusy%0d", c), int'(hz.mdu_busy), (c >= 2) ? 1 : 0);
         if (c < LAT) begin
            chk($sformatf("mduFlushE%0d", c), int'(hz.flush_e), 0);
            chk($sformatf("mduStallD%0d", c), int'(hz.stall_d), 1);
         end
         nextCycle();
      end
      idle();
      settle(); chk("mduDone", int'(hz.mdu_busy), 0);
      chk("mduDoneStall", int'(hz.stall_e), 0);

      // redirect flush
      idle(); hz.pc_src_d = 1'b1;
      settle(); chk("flushD", int'(hz.flush_d), 1);
      setLoadUse5();
      settle(); chk("flushDStalled", int'(hz.flush_d), 0);
      idle(); hz.jump_d = 1'b1;
      settle(); chk("flushDJump", int'(hz.flush_d), 1);

      // reset in the 2nd cycle of an MDU op
      idle(); nextCycle();
      hz.mdu_op_e = 1'b1;
      nextCycle();
      settle(); chk("midBusy", int'(hz.mdu_busy), 1);
      reset = 1'b0;
      #1 chk("rstAbortBusy", int'(hz.mdu_busy), 0);
      hz.mdu_op_e = 1'b0;
      #3 reset = 1'b1;
      nextCycle();
      settle();
      chk("relStallF", int'(hz.stall_f), 0);
      chk("relStallE", int'(hz.stall_e), 0);
      chk("relFlushM", int'(hz.flush_m), 0);

`ifdef HAZARD_PERF_CNT_EN
      reset = 1'b0; #2 reset = 1'b1;
      idle(); setLoadUse5();
      for (int c = 0; c < 10; c++) nextCycle();
      idle();
      settle(); chk("perfStall10", int'(stallCycles), 10);
      chk("perfFwd0", int'(fwdEvents), 0);
`endif

      // randomized phase against the model
      idle();
      nextCycle();
      chkEn = 1'b1;
      for (int i = 0; i < 600; i++) begin
         hz.rs_d = RAW'($urandom_range(0, 3));
         hz.rt_d = RAW'($urandom_range(0, 3));
         hz.rs_e = RAW'($urandom_range(0, 3));
         hz.rt_e = RAW'($urandom_range(0, 3));
         hz.write_reg_e = RAW'($urandom_range(0, 3));
         hz.write_reg_m = RAW'($urandom_range(0, 3));
         hz.write_reg_w = RAW'($urandom_range(0, 3));
         hz.reg_write_e = 1'($urandom_range(0, 1));
         hz.reg_write_m = 1'($urandom_range(0, 1));
         hz.reg_write_w = 1'($urandom_range(0, 1));
         hz.mem_to_reg_e = 1'($urandom_range(0, 3) == 0);
         hz.mem_to_reg_m = 1'($urandom_range(0, 3) == 0);
         hz.branch_d = 1'($urandom_range(0, 2) == 0);
         hz.pc_src_d = 1'($urandom_range(0, 3) == 0);
         hz.jump_d = 1'($urandom_range(0, 5) == 0);
         // a resident op stays in Execute until its last cycle has passed
         hz.mdu_op_e = (occ > 0) ? 1'b1 : 1'($urandom_range(0, 5) == 0);
         if (i == 300) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
         end
         nextCycle();
      end
      chkEn = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
